// File: rtl/ows_rom_cmd_ctrl.sv
// ows_rom_cmd_ctrl
// ROM-function controller for the 1-wire slave. After each bus reset it
// accepts one ROM command byte and then sequences the 64-bit ROM stream
// (56 UID bits, LSB first, followed by the CRC8 that is computed serially
// over those bits). READ ROM shifts the stream out in read slots. MATCH ROM
// compares each master write bit against the stream. SKIP ROM selects the
// device immediately.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   bus_reset    1-cycle pulse, 1-wire reset/presence completed
//   cmd_valid    1-cycle pulse, cmd_byte holds a ROM command
//   cmd_byte     ROM command opcode
//   uid          family code + serial number, captured on each command
//   slot_req     1-cycle pulse, master read slot needs a bit
//   rx_bit_valid 1-cycle pulse, master write slot sampled into rx_bit
//   rx_bit       sampled master bit
//   tx_bit       bit for the current read slot (1 = release bus)
//   tx_bit_valid 1-cycle pulse, one cycle after an accepted slot_req
//   selected     device addressed, function layer may proceed
//   busy         READ_TX or MATCH_RX in progress
//   cmd_err      1-cycle pulse, unsupported ROM opcode received
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | after rst, waiting for the first bus reset
// WAIT_CMD | bus reset seen, waiting for the ROM command byte
// READ_TX  | READ ROM: one stream bit per slot_req
// MATCH_RX | MATCH ROM: one stream bit compared per rx_bit_valid
// SELECTED | device addressed, held until bus reset
// LOCKED   | mismatch or unsupported opcode, held until bus reset

module ows_rom_cmd_ctrl #(
  parameter int          UID_SERIAL_DATA_WIDTH = 56,
  parameter int          CRC_WIDTH             = 8,
  parameter logic [7:0]  CMD_READ_ROM          = 8'h33,
  parameter logic [7:0]  CMD_MATCH_ROM         = 8'h55,
  parameter logic [7:0]  CMD_SKIP_ROM          = 8'hCC
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              bus_reset,
  input  logic                              cmd_valid,
  input  logic [7:0]                        cmd_byte,
  input  logic [UID_SERIAL_DATA_WIDTH-1:0]  uid,
  input  logic                              slot_req,
  input  logic                              rx_bit_valid,
  input  logic                              rx_bit,
  output logic                              tx_bit,
  output logic                              tx_bit_valid,
  output logic                              selected,
  output logic                              busy,
  output logic                              cmd_err
);

  localparam int STREAM_LEN = UID_SERIAL_DATA_WIDTH + CRC_WIDTH;
  localparam int IDX_W      = $clog2(STREAM_LEN);
  localparam int CRC_IW     = $clog2(CRC_WIDTH);

  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(STREAM_LEN - 1);
  localparam logic [IDX_W-1:0]     CRC_IDX0 = IDX_W'(UID_SERIAL_DATA_WIDTH);
  // x^8+x^5+x^4+1 in LSB-first form; bit 7 comes from the feedback shift-in.
  localparam logic [CRC_WIDTH-1:0] CRC_POLY = CRC_WIDTH'(8'h0C);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_CMD,
    READ_TX,
    MATCH_RX,
    SELECTED,
    LOCKED
  } state_t;

  state_t                           state;
  logic [IDX_W-1:0]                 bit_idx;
  logic [CRC_WIDTH-1:0]             crc;
  logic [UID_SERIAL_DATA_WIDTH-1:0] uid_reg;

  // Zero-extend the UID to the stream length so bit_idx can index it
  // directly; the upper entries are never selected.
  logic [STREAM_LEN-1:0]            uid_ext;
  logic [CRC_IW-1:0]                crc_sel;
  logic                             in_uid;
  logic                             exp_bit;
  logic                             crc_fb;
  logic [CRC_WIDTH-1:0]             crc_next;
  logic                             at_last;

  assign uid_ext  = {{CRC_WIDTH{1'b0}}, uid_reg};
  assign crc_sel  = CRC_IW'(bit_idx - CRC_IDX0);
  assign in_uid   = (bit_idx < CRC_IDX0);
  assign exp_bit  = in_uid ? uid_ext[bit_idx] : crc[crc_sel];
  assign crc_fb   = crc[0] ^ exp_bit;
  // The CRC only advances over UID bits; it is frozen while being sent.
  assign crc_next = in_uid ? ({crc_fb, crc[CRC_WIDTH-1:1]} ^ (crc_fb ? CRC_POLY : '0))
                           : crc;
  assign at_last  = (bit_idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      bit_idx      <= '0;
      crc          <= '0;
      uid_reg      <= '0;
      tx_bit       <= 1'b1;
      tx_bit_valid <= 1'b0;
      selected     <= 1'b0;
      busy         <= 1'b0;
      cmd_err      <= 1'b0;
    end else begin
      tx_bit       <= 1'b1;
      tx_bit_valid <= 1'b0;
      cmd_err      <= 1'b0;

      if (bus_reset) begin
        state    <= WAIT_CMD;
        selected <= 1'b0;
        busy     <= 1'b0;
        bit_idx  <= '0;
        crc      <= '0;
      end else begin
        case (state)
          WAIT_CMD: begin
            if (cmd_valid) begin
              uid_reg <= uid;
              if (cmd_byte == CMD_READ_ROM) begin
                state <= READ_TX;
                busy  <= 1'b1;
              end else if (cmd_byte == CMD_MATCH_ROM) begin
                state <= MATCH_RX;
                busy  <= 1'b1;
              end else if (cmd_byte == CMD_SKIP_ROM) begin
                state    <= SELECTED;
                selected <= 1'b1;
              end else begin
                state   <= LOCKED;
                cmd_err <= 1'b1;
              end
            end
          end

          READ_TX: begin
            if (slot_req) begin
              tx_bit       <= exp_bit;
              tx_bit_valid <= 1'b1;
              crc          <= crc_next;
              if (at_last) begin
                state    <= SELECTED;
                selected <= 1'b1;
                busy     <= 1'b0;
              end else begin
                bit_idx <= bit_idx + 1'b1;
              end
            end
          end

          MATCH_RX: begin
            if (rx_bit_valid) begin
              if (rx_bit != exp_bit) begin
                state <= LOCKED;
                busy  <= 1'b0;
              end else begin
                crc <= crc_next;
                if (at_last) begin
                  state    <= SELECTED;
                  selected <= 1'b1;
                  busy     <= 1'b0;
                end else begin
                  bit_idx <= bit_idx + 1'b1;
                end
              end
            end
          end

          IDLE, SELECTED, LOCKED: begin
          end

          default: begin
            state    <= IDLE;
            selected <= 1'b0;
            busy     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ows_rom_cmd_ctrl.sv
// Self-checking bench for ows_rom_cmd_ctrl. Expected ROM streams come from a
// byte-wise Dallas CRC8 model; directed scenarios plus randomized UIDs,
// slot gaps and cross-traffic on the unused strobe.

module tb_ows_rom_cmd_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        bus_reset;
  logic        cmd_valid;
  logic [7:0]  cmd_byte;
  logic [55:0] uid;
  logic        slot_req;
  logic        rx_bit_valid;
  logic        rx_bit;
  logic        tx_bit;
  logic        tx_bit_valid;
  logic        selected;
  logic        busy;
  logic        cmd_err;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ows_rom_cmd_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .bus_reset    (bus_reset),
    .cmd_valid    (cmd_valid),
    .cmd_byte     (cmd_byte),
    .uid          (uid),
    .slot_req     (slot_req),
    .rx_bit_valid (rx_bit_valid),
    .rx_bit       (rx_bit),
    .tx_bit       (tx_bit),
    .tx_bit_valid (tx_bit_valid),
    .selected     (selected),
    .busy         (busy),
    .cmd_err      (cmd_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: Dallas CRC8 computed byte by byte with the reflected 0x8C form.
  function automatic logic [63:0] rom_stream(input logic [55:0] id);
    logic [7:0] c;
    logic [7:0] b;
    c = 8'h00;
    for (int k = 0; k < 7; k++) begin
      b = id[k*8 +: 8];
      for (int j = 0; j < 8; j++) begin
        if (((c ^ b) & 8'h01) != 8'h00) c = (c >> 1) ^ 8'h8C;
        else                            c = c >> 1;
        b = b >> 1;
      end
    end
    return {c, id};
  endfunction

  function automatic logic [55:0] rand_uid();
    return 56'({$urandom(), $urandom()});
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus_reset    = 1'b0;
    cmd_valid    = 1'b0;
    slot_req     = 1'b0;
    rx_bit_valid = 1'b0;
    rx_bit       = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_tx_bit"},       tx_bit,       1);
    chk({tag, "_tx_bit_valid"}, tx_bit_valid, 0);
    chk({tag, "_selected"},     selected,     0);
    chk({tag, "_busy"},         busy,         0);
    chk({tag, "_cmd_err"},      cmd_err,      0);
  endtask

  task automatic do_bus_reset();
    bus_reset = 1'b1;
    step();
    bus_reset = 1'b0;
    chk("bus_reset_selected", selected, 0);
    chk("bus_reset_busy",     busy,     0);
  endtask

  task automatic send_cmd(input logic [7:0] c);
    cmd_byte  = c;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    cmd_byte  = 8'h00;
  endtask

  // READ ROM for nbits slots; returns the bits observed on tx_bit.
  task automatic run_read(input logic [55:0] id, input int nbits, input bit noise,
                          output logic [63:0] got);
    logic [63:0] s;
    s   = rom_stream(id);
    got = '0;
    uid = id;
    do_bus_reset();
    send_cmd(8'h33);
    chk("read_busy_start", busy, 1);
    uid = rand_uid();
    for (int i = 0; i < nbits; i++) begin
      repeat (noise ? $urandom_range(0, 2) : 0) begin
        rx_bit_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        rx_bit       = 1'($urandom_range(0, 1));
        step();
        rx_bit_valid = 1'b0;
        chk("read_gap_valid", tx_bit_valid, 0);
      end
      slot_req     = 1'b1;
      rx_bit_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      rx_bit       = 1'($urandom_range(0, 1));
      step();
      slot_req     = 1'b0;
      rx_bit_valid = 1'b0;
      got[i] = tx_bit;
      chk($sformatf("read_valid_%0d", i), tx_bit_valid, 1);
      chk($sformatf("read_bit_%0d", i),   tx_bit,       s[i]);
      chk($sformatf("read_sel_%0d", i),   selected,     (i == 63));
      chk($sformatf("read_busy_%0d", i),  busy,         (i != 63));
    end
  endtask

  // MATCH ROM; flip >= 0 inverts that master bit and expects lock-out.
  task automatic run_match(input logic [55:0] id, input int flip, input bit noise);
    logic [63:0] s;
    s   = rom_stream(id);
    uid = id;
    do_bus_reset();
    send_cmd(8'h55);
    chk("match_busy_start", busy, 1);
    uid = rand_uid();
    for (int i = 0; i < 64; i++) begin
      repeat (noise ? $urandom_range(0, 2) : 0) begin
        slot_req = 1'($urandom_range(0, 1));
        step();
        slot_req = 1'b0;
        chk("match_gap_valid", tx_bit_valid, 0);
      end
      rx_bit       = s[i] ^ (i == flip);
      rx_bit_valid = 1'b1;
      slot_req     = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      step();
      rx_bit_valid = 1'b0;
      slot_req     = 1'b0;
      chk($sformatf("match_txv_%0d", i), tx_bit_valid, 0);
      chk($sformatf("match_txb_%0d", i), tx_bit,       1);
      if (i == flip) begin
        chk($sformatf("match_lock_sel_%0d", i),  selected, 0);
        chk($sformatf("match_lock_busy_%0d", i), busy,     0);
        break;
      end
      chk($sformatf("match_sel_%0d", i),  selected, (i == 63));
      chk($sformatf("match_busy_%0d", i), busy,     (i != 63));
    end
    if (flip >= 0) begin
      repeat (4) begin
        rx_bit_valid = 1'b1;
        rx_bit       = 1'($urandom_range(0, 1));
        slot_req     = 1'b1;
        step();
        rx_bit_valid = 1'b0;
        slot_req     = 1'b0;
        chk("locked_sel",  selected,     0);
        chk("locked_busy", busy,         0);
        chk("locked_txv",  tx_bit_valid, 0);
      end
    end
  endtask

  initial begin
    logic [63:0] got;
    logic [55:0] id;
    int          mode;

    clear_inputs();
    cmd_byte = 8'h00;
    uid      = '0;
    rst      = 1'b1;
    step();
    step();
    rst = 1'b0;
    check_reset_outputs("reset");

    // Command without a preceding bus reset stays in IDLE.
    send_cmd(8'h33);
    chk("idle_cmd_busy", busy, 0);
    slot_req = 1'b1;
    step();
    slot_req = 1'b0;
    chk("idle_slot_valid", tx_bit_valid, 0);

    // Directed READ ROM with the reference UID.
    run_read(56'h00000001B81C02, 64, 1'b0, got);
    chk("read_stream", got, 64'hA200000001B81C02);
    slot_req = 1'b1;
    step();
    slot_req = 1'b0;
    chk("read_65th_valid", tx_bit_valid, 0);
    chk("read_65th_sel",   selected,     1);

    // Directed MATCH ROM, clean and with bit 57 flipped (CRC A0).
    run_match(56'h00000001B81C02, -1, 1'b0);
    run_match(56'h00000001B81C02, 57, 1'b0);
    send_cmd(8'hCC);
    chk("locked_cmd_ignored", selected, 0);
    do_bus_reset();
    send_cmd(8'hCC);
    chk("after_lock_skip_sel", selected, 1);

    // SKIP ROM, then unsupported opcode.
    do_bus_reset();
    send_cmd(8'hCC);
    chk("skip_sel",  selected, 1);
    chk("skip_busy", busy,     0);
    send_cmd(8'hF0);
    chk("selected_cmd_no_err", cmd_err, 0);
    chk("selected_cmd_hold",   selected, 1);
    do_bus_reset();
    send_cmd(8'hF0);
    chk("bad_cmd_err", cmd_err, 1);
    chk("bad_cmd_sel", selected, 0);
    step();
    chk("bad_cmd_err_pulse", cmd_err, 0);
    send_cmd(8'h33);
    chk("locked_read_busy", busy,    0);
    chk("locked_read_err",  cmd_err, 0);

    // READ ROM aborted by bus reset after 20 bits restarts at byte 02.
    run_read(56'h00000001B81C02, 20, 1'b0, got);
    run_read(56'h00000001B81C02, 8, 1'b0, got);
    chk("restart_first_byte", got[7:0], 8'h02);

    // rst in the middle of MATCH ROM.
    id = 56'h00000001B81C02;
    uid = id;
    do_bus_reset();
    send_cmd(8'h55);
    for (int i = 0; i < 10; i++) begin
      rx_bit       = id[i];
      rx_bit_valid = 1'b1;
      step();
      rx_bit_valid = 1'b0;
    end
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_outputs("mid_match_rst");
    send_cmd(8'h55);
    chk("post_rst_cmd_busy", busy, 0);
    rx_bit_valid = 1'b1;
    rx_bit       = id[0];
    slot_req     = 1'b1;
    step();
    clear_inputs();
    chk("post_rst_idle_txv", tx_bit_valid, 0);
    chk("post_rst_idle_sel", selected,     0);

    // Randomized sessions.
    for (int r = 0; r < 24; r++) begin
      id   = rand_uid();
      mode = $urandom_range(0, 2);
      if (mode == 0) begin
        run_read(id, 64, 1'b1, got);
        chk("rand_read_stream", got, rom_stream(id));
      end else if (mode == 1) begin
        run_match(id, -1, 1'b1);
      end else begin
        run_match(id, $urandom_range(0, 63), 1'b1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ows_rom_cmd_ctrl.md
Name: ows_rom_cmd_ctrl

Overview:
ROM-function controller for the 1-wire slave. It sits between the byte/bit-slot layer and the UID datapath. It accepts a ROM command byte after each bus reset, then sequences the 64-bit ROM stream: 56 UID bits followed by the serially computed CRC8. The stream is shifted out for READ ROM and compared against master bits for MATCH ROM. It drives the device-selected flag used by the function-command layer.

Parameters:
UID_SERIAL_DATA_WIDTH, 56, UID bits (family + serial) sent before the CRC
CRC_WIDTH, 8, CRC bits appended; total stream = 64
CMD_READ_ROM, 8'h33, READ ROM opcode
CMD_MATCH_ROM, 8'h55, MATCH ROM opcode
CMD_SKIP_ROM, 8'hCC, SKIP ROM opcode

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
bus_reset  input  1  1-cycle pulse: 1-wire reset/presence completed
cmd_valid  input  1  1-cycle pulse: cmd_byte holds a received ROM command
cmd_byte  input  8  ROM command byte
uid  input  56  UID; uid[7:0] = family code; sent LSB first
slot_req  input  1  1-cycle pulse: master read slot needs a bit
rx_bit_valid  input  1  1-cycle pulse: master write slot sampled
rx_bit  input  1  sampled master bit, valid with rx_bit_valid
tx_bit  output  1  bit to drive in the current read slot; 1 = release bus
tx_bit_valid  output  1  1-cycle pulse, one cycle after an accepted slot_req
selected  output  1  device addressed; function layer may proceed
busy  output  1  high in READ_TX or MATCH_RX
cmd_err  output  1  1-cycle pulse: unsupported opcode received

Behaviour:
- Reset (rst=1): state=IDLE; bit_idx=0; crc=0; tx_bit=1; tx_bit_valid=0; selected=0; busy=0; cmd_err=0.
- States: IDLE, WAIT_CMD, READ_TX, MATCH_RX, SELECTED, LOCKED.
- Priority: rst > bus_reset > cmd_valid/slot_req/rx_bit_valid.
- bus_reset in any state: next state WAIT_CMD; selected=0; bit_idx=0; crc=0. Any in-progress stream is abandoned.
- WAIT_CMD + cmd_valid:
  - uid is captured into an internal register; later uid changes are ignored until the next command.
  - 0x33 → READ_TX.
  - 0x55 → MATCH_RX.
  - 0xCC → SELECTED; selected=1 on the next cycle.
  - Other opcodes (including 0xF0 SEARCH, unsupported): cmd_err pulses 1 cycle → LOCKED.
- cmd_valid outside WAIT_CMD is ignored, with no cmd_err.
- Expected bit e(i), i = bit_idx 0..63:
  - i<56: uid_reg[i].
  - i>=56: crc[i-56].
- CRC8 (Dallas, x^8+x^5+x^4+1), LSB-first serial update, for i<56 only:
  - fb = crc[0]^e(i)
  - crc = {fb, crc[7:1]} ^ (fb ? 8'h0C : 8'h00)
  - crc is frozen for i>=56.
- READ_TX:
  - slot_req at cycle t: tx_bit=e(bit_idx) and tx_bit_valid=1 at t+1; crc and bit_idx update at t+1.
  - After the bit with bit_idx=63 → SELECTED, selected=1 in the same cycle as the last tx_bit_valid.
  - rx_bit_valid is ignored.
- MATCH_RX:
  - rx_bit_valid at t: compare rx_bit with e(bit_idx).
  - Mismatch → LOCKED at t+1; selected stays 0.
  - Match → bit_idx+1, crc updated.
  - Match at bit_idx=63 → SELECTED at t+1.
  - slot_req is ignored: tx_bit=1, no tx_bit_valid.
- Outside READ_TX, slot_req produces no tx_bit_valid; tx_bit stays 1.
- SELECTED and LOCKED hold until bus_reset or rst. IDLE is left only by bus_reset.
- bit_idx is 6 bits and never wraps: the transition out of the state occurs at 63.
- slot_req and rx_bit_valid in the same cycle: only the one relevant to the current state is acted on.
- busy = (state==READ_TX) || (state==MATCH_RX), registered.

Test Plan:
- uid=56'h00000001B81C02, bus_reset, cmd 0x33, 64 slot_req → tx bytes LSB-first 02 1C B8 01 00 00 00 A2; selected=1 after bit 63; 65th slot_req gives no tx_bit_valid.
- Same uid, bus_reset, cmd 0x55, feed the 64-bit stream ending in A2 → selected=1 one cycle after the 64th rx_bit_valid.
- MATCH with bit 57 flipped (CRC 0xA0) → LOCKED; selected=0; further slot_req/rx bits ignored; next bus_reset → WAIT_CMD.
- bus_reset, cmd 0xCC → selected=1 next cycle. cmd 0xF0 → cmd_err 1-cycle pulse, selected=0, LOCKED.
- READ ROM, bus_reset after 20 bits → WAIT_CMD, bit_idx=0; a following READ ROM restarts at byte 02.
- rst asserted mid-MATCH_RX → all outputs at reset values next cycle; cmd_valid without a prior bus_reset is ignored (IDLE).
